register_array_streamer: RTL

REGISTER_ARRAY_STREAMER -- requirements
Module: register_array_streamer

---
 rtl/register_array_streamer.sv | 88 ++++++++
 1 files changed

// File: rtl/register_array_streamer.sv
//------------------------------------------------------------------------------
// Module      : register_array_streamer
// Description : Snapshots a parallel register array on start and streams it
//               out one entry per beat over a valid/ready interface.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_array_streamer #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 16,
    parameter int IDXW  = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] reg_in [SIZE],
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(SIZE - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  idx_d;
    logic [WIDTH-1:0] snap_q [SIZE];
    logic             done_q;

    logic             w_xfer;
    logic             w_final;

    assign w_xfer  = (state_q == S_SEND) && out_ready;
    assign w_final = w_xfer && (idx_q == C_LAST_IDX);
    assign idx_d   = w_final ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            done_q <= w_final;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_q  <= reg_in;
                        idx_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    // start is deliberately ignored here, even on the final beat
                    if (w_xfer) begin
                        idx_q <= idx_d;
                        if (w_final) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_SEND);
    assign out_valid = busy;
    assign out_data  = busy ? snap_q[idx_q] : '0;
    assign out_index = busy ? idx_q : '0;
    assign out_last  = busy && (idx_q == C_LAST_IDX);
    assign done      = done_q;

endmodule

`default_nettype wire
